// File: rtl/mux4_rr_scheduler.sv
// Round-robin control stage around a 4:1 mux: grants one requester, lets the mux
// settle for a cycle, captures its output and hands it downstream on valid/ready.
module mux4_rr_scheduler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NCH-1:0]     ack_q, ack_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   cand;
  logic               win_found;

  // First requester found scanning upward from the round-robin pointer.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Capture regardless of whether the winner still requests.
        out_data_d  = mux_out;
        out_valid_d = 1'b1;
        ack_d       = NCH'(1) << sel_q;
        ptr_d       = sel_q + SEL_W'(1);
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/mux4_rr_scheduler.md
Name: mux4_rr_scheduler

Overview:
- Control stage wrapped around the 4-bit 4:1 mux.
- Arbitrates four requesting channels round-robin and drives the mux `sel`.
- Captures the mux output into a register and presents it downstream on a valid/ready handshake.
- Closes the loop: sel → mux → mux_out → registered output, with a per-channel acknowledge back to the sources.

Parameters:
- WIDTH, 4, data width of mux_out / out_data; must match the mux data width.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit i = channel i (mux input in(i+1)).
- mux_out  input  WIDTH  data returned from the 4:1 mux for the current sel.
- out_ready  input  1  downstream accepts out_data when high with out_valid.
- sel  output  2  select driven to the 4:1 mux; registered.
- ack  output  4  one-hot, one-cycle pulse marking the channel whose data was captured.
- out_data  output  WIDTH  captured mux data; registered.
- out_valid  output  1  out_data valid; held until accepted.
- busy  output  1  high in any state other than IDLE.
- xfer_cnt  output  CNT_W  count of completed downstream handshakes.

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high, sampled on the rising edge; it overrides all other inputs.
- Reset values: state=IDLE, sel=2'b00, ack=4'b0000, out_data=0, out_valid=0, busy=0, xfer_cnt=0, round-robin pointer ptr=0.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE, req==0: stay in IDLE; all outputs hold.
- IDLE, req!=0: pick the winner = first set bit searching ptr, ptr+1, … mod 4. Register sel<=winner and go to SETTLE.
- Requests are sampled only in IDLE.
- SETTLE: sel is stable for one full cycle so the combinational mux output settles. At the end of SETTLE:
  - out_data<=mux_out
  - out_valid<=1
  - ack[sel]<=1 for exactly one cycle
  - ptr<=sel+1 mod 4 (3 wraps to 0)
  - go to HOLD
- SETTLE ignores req. If req[sel] drops during SETTLE, the capture and ack still occur.
- HOLD: out_data and out_valid are held stable until out_ready=1. On out_valid&&out_ready:
  - out_valid<=0
  - xfer_cnt<=xfer_cnt+1, wrapping from 2^CNT_W-1 to 0
  - go to IDLE
- out_ready is ignored outside HOLD.
- ack deasserts in the cycle after it pulses.
- sel holds its last value in IDLE and HOLD; it changes only on the IDLE→SETTLE transition.
- Latency: req seen at edge N → sel valid after edge N. out_valid and ack are high after edge N+1. Minimum 3 cycles per transfer when out_ready is held high (one IDLE bubble per transfer).
- Fairness: a continuously asserted request is served within 4 transfers. With req=4'b1111 the grant order is 0,1,2,3,0,…
- Reset mid-operation (SETTLE or HOLD): the transfer is discarded. No ack, out_valid=0, xfer_cnt is not incremented, ptr returns to 0.
- Sources must hold req[i] until they see ack[i]. The block does not latch requests.

Test Plan:
- Reset then single request: req=4'b0100, mux_in3=4'b1100, out_ready=1 → sel=2'b10 one cycle after req. The following cycle has out_data=4'b1100, out_valid=1, ack=4'b0100 (one cycle). xfer_cnt=1 after the handshake.
- Round-robin: req=4'b1111, mux inputs 1010/0101/1100/0011, out_ready=1 → out_data sequence 1010, 0101, 1100, 0011, 1010. ack sequence 0001, 0010, 0100, 1000, 0001.
- Back-pressure: out_ready=0 for 5 cycles during HOLD → out_valid stays 1, out_data stays constant, and no new sel change despite pending req. Raising out_ready gives one handshake and xfer_cnt +1.
- Pointer wrap and skip: after granting channel 3, set req=4'b0110 → the next grant is channel 1 (sel=2'b01), not channel 2.
- Reset mid-HOLD: assert rst for 1 cycle while out_valid=1 → out_valid=0, sel=2'b00, xfer_cnt unchanged from its reset value of 0. The next req=4'b1000 is granted from ptr=0 and yields sel=2'b11.
- Counter wrap: with CNT_W=2, complete 5 transfers → xfer_cnt reads 1,2,3,0,1.
